video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
Raster timing generator that produces the pixel-position, data-enable and sync controls feeding the TMDS encoder channels.
- `de` drives the encoder `de` on all three channels.
- `{vsync, hsync}` drives the `c[1:0]` control pair of the blue channel.
- `x`/`y` go to the pixel source, which must present the matching `d` in the same cycle.
- Advances one pixel per clock on which the clock-enable strobe is high, so one pixel-rate domain serves any mode.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level (0 = active-low)
- W, 12, width of position counters and x/y outputs

Ports:
- clock  in  1  pixel-domain clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  pixel advance strobe; the raster advances only on clocks where ce=1
- de  out  1  active-video enable
- hsync  out  1  horizontal sync, level per H_POL
- vsync  out  1  vertical sync, level per V_POL
- x  out  W  horizontal position of the current pixel
- y  out  W  vertical position of the current line
- sof  out  1  start-of-frame strobe
- sol  out  1  start-of-line strobe

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK; V_TOTAL likewise from the V_* parameters.
- Both totals must fit in W bits; a violation is an elaboration error.
- Every parameter must be ≥1.
- Internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) hold the position of the NEXT pixel to be emitted.
- Segment order on each axis: active, front porch, sync, back porch.
- Reset (synchronous, highest priority, overrides ce):
  - h=0, v=0, de=0, x=0, y=0, sof=0, sol=0.
  - hsync = ~H_POL and vsync = ~V_POL (deasserted levels).
- Clock edge with ce=1 (not in reset): all outputs register the decode of the current (h,v), then the counters advance.
  - de <= (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync <= H_POL when H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC; otherwise ~H_POL.
  - vsync <= V_POL when V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC; otherwise ~V_POL.
  - vsync is decoded from v alone, so it changes only at the pixel where h=0.
  - x <= h, y <= v. x and y are reported in blanking as well.
  - sol <= (h == 0); sof <= (h == 0 && v == 0).
  - Advance: if h == H_TOTAL-1, then h <= 0 and v wraps (V_TOTAL-1 -> 0, else v+1). Otherwise h <= h+1.
- Clock edge with ce=0: counters and all level outputs (de, hsync, vsync, x, y) hold.
  - sof and sol clear to 0, so each strobe is high for exactly one clock.
- Latency: pixel (h,v) is visible on the outputs from the ce edge that consumes it.
  - The first ce after reset emits (0,0) with de=1, sof=1, sol=1.
- ce held high continuously: one pixel per clock, one frame every H_TOTAL·V_TOTAL clocks, no bubbles at line or frame wrap.
- reset asserted mid-frame: the next frame starts at (0,0) on the first ce after reset release. No partial-line cleanup.
- ce asserted in the same cycle as reset: ignored; reset wins.

Test Plan:
- Small mode H=4/1/2/1, V=3/1/1/1, polarities 0, ce=1 constant, after reset:
  - Clocks 1-8 give x=0..7 with de=1,1,1,1,0,0,0,0 and hsync=1,1,1,1,1,0,0,1.
  - sol=1 at clocks 1, 9, 17.
  - sof=1 only at clocks 1 and 49.
- Same mode: vsync=0 for exactly the 8 pixels with y=4.
  - de=0 for all pixels with y≥3.
  - y wraps 5->0 after clock 48.
- Same mode, ce pattern 1,0,0,1 repeating:
  - Outputs change only on ce edges; x sequence 0,1,2… unchanged.
  - sof is 1 for a single clock and low during the ce=0 clocks that follow.
- Same mode with H_POL=1, V_POL=1:
  - Reset gives hsync=0, vsync=0.
  - hsync=1 at x=5,6; vsync=1 across y=4.
- Default 640x480 mode, ce=1:
  - de high for exactly 640 consecutive clocks per active line.
  - 307200 de-high clocks per frame.
  - Frame period = 420000 clocks between sof pulses.
- Assert reset for one clock at x=300, y=200, then ce=1:
  - First post-reset ce gives x=0, y=0, de=1, sof=1.
  - During reset: de=0, sync outputs at deasserted levels.

Source files
------------

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator: position, data enable and sync for TMDS encoders
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int W        = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ce,
  output logic         de,
  output logic         hsync,
  output logic         vsync,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         sof,
  output logic         sol
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Reject timings the counters cannot represent, and empty segments
  if ((W < 1) || (W > 30) || (H_TOTAL > (1 << W) - 1) || (V_TOTAL > (1 << W) - 1)) begin : g_bad_width
    $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in W bits");
  end
  if ((H_ACTIVE < 1) || (H_FRONT < 1) || (H_SYNC < 1) || (H_BACK < 1) ||
      (V_ACTIVE < 1) || (V_FRONT < 1) || (V_SYNC < 1) || (V_BACK < 1)) begin : g_bad_segment
    $error("video_timing_gen: every timing segment must be at least one unit long");
  end

  localparam logic [W-1:0] LP_H_ACT   = W'(H_ACTIVE);
  localparam logic [W-1:0] LP_HS_BEG  = W'(H_ACTIVE + H_FRONT);
  localparam logic [W-1:0] LP_HS_END  = W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [W-1:0] LP_H_LAST  = W'(H_TOTAL - 1);
  localparam logic [W-1:0] LP_V_ACT   = W'(V_ACTIVE);
  localparam logic [W-1:0] LP_VS_BEG  = W'(V_ACTIVE + V_FRONT);
  localparam logic [W-1:0] LP_VS_END  = W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [W-1:0] LP_V_LAST  = W'(V_TOTAL - 1);
  localparam logic         LP_H_POL   = (H_POL != 0);
  localparam logic         LP_V_POL   = (V_POL != 0);

  // r_h/r_v address the next pixel to be emitted; outputs carry the pixel just consumed
  logic [W-1:0] r_h;
  logic [W-1:0] r_v;
  logic [W-1:0] r_x;
  logic [W-1:0] r_y;
  logic         r_de;
  logic         r_hsync;
  logic         r_vsync;
  logic         r_sof;
  logic         r_sol;

  logic         w_de;
  logic         w_hs_on;
  logic         w_vs_on;
  logic         w_h_last;
  logic         w_v_last;
  logic         w_h_zero;
  logic         w_v_zero;

  assign w_de     = (r_h < LP_H_ACT) && (r_v < LP_V_ACT);
  assign w_hs_on  = (r_h >= LP_HS_BEG) && (r_h < LP_HS_END);
  assign w_vs_on  = (r_v >= LP_VS_BEG) && (r_v < LP_VS_END);
  assign w_h_last = (r_h == LP_H_LAST);
  assign w_v_last = (r_v == LP_V_LAST);
  assign w_h_zero = (r_h == '0);
  assign w_v_zero = (r_v == '0);

  // Register the decode of the current position on each ce, then step the raster
  always_ff @(posedge clock) begin
    if (reset) begin
      r_h     <= '0;
      r_v     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_de    <= 1'b0;
      r_hsync <= ~LP_H_POL;
      r_vsync <= ~LP_V_POL;
      r_sof   <= 1'b0;
      r_sol   <= 1'b0;
    end else if (ce) begin
      r_de    <= w_de;
      r_hsync <= w_hs_on ? LP_H_POL : ~LP_H_POL;
      r_vsync <= w_vs_on ? LP_V_POL : ~LP_V_POL;
      r_x     <= r_h;
      r_y     <= r_v;
      r_sol   <= w_h_zero;
      r_sof   <= w_h_zero && w_v_zero;
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end else begin
      // Strobes last one clock; levels and counters hold
      r_sof <= 1'b0;
      r_sol <= 1'b0;
    end
  end

  assign de    = r_de;
  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign x     = r_x;
  assign y     = r_y;
  assign sof   = r_sof;
  assign sol   = r_sol;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed bench for video_timing_gen
module tb_video_timing_gen;

  logic clock;
  logic reset;
  logic ce;

  logic        de_s, hs_s, vs_s, sof_s, sol_s;
  logic [11:0] x_s, y_s;
  logic        de_p, hs_p, vs_p, sof_p, sol_p;
  logic [11:0] x_p, y_p;
  logic        de_d, hs_d, vs_d, sof_d, sol_d;
  logic [11:0] x_d, y_d;

  int checks;
  int failures;

  // Small mode: x 0-3 active, 4 front, 5-6 sync, 7 back; y 0-2 active, 3 front, 4 sync, 5 back
  localparam logic [7:0] DE_X = 8'b0000_1111;
  localparam logic [7:0] HS_X = 8'b1001_1111;
  localparam logic [5:0] DE_Y = 6'b00_0111;
  localparam logic [5:0] VS_Y = 6'b10_1111;

  video_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(0), .V_POL(0), .W(12)
  ) dut_s (
    .clock(clock), .reset(reset), .ce(ce),
    .de(de_s), .hsync(hs_s), .vsync(vs_s), .x(x_s), .y(y_s), .sof(sof_s), .sol(sol_s)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1), .V_POL(1), .W(12)
  ) dut_p (
    .clock(clock), .reset(reset), .ce(ce),
    .de(de_p), .hsync(hs_p), .vsync(vs_p), .x(x_p), .y(y_p), .sof(sof_p), .sol(sol_p)
  );

  video_timing_gen dut_d (
    .clock(clock), .reset(reset), .ce(ce),
    .de(de_d), .hsync(hs_d), .vsync(vs_d), .x(x_d), .y(y_d), .sof(sof_d), .sol(sol_d)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b1;
    ce    = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ce    = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    ce    = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    ce    = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (x_s !== 12'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", x_s); end
    checks++; if (y_s !== 12'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", y_s); end
    checks++; if (de_s !== 1'b0) begin failures++; $display("FAIL reset_de got=%b exp=0", de_s); end
    checks++; if (hs_s !== 1'b1) begin failures++; $display("FAIL reset_hsync got=%b exp=1", hs_s); end
    checks++; if (vs_s !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%b exp=1", vs_s); end
    checks++; if (sof_s !== 1'b0) begin failures++; $display("FAIL reset_sof got=%b exp=0", sof_s); end
    checks++; if (sol_s !== 1'b0) begin failures++; $display("FAIL reset_sol got=%b exp=0", sol_s); end
    checks++; if (hs_p !== 1'b0) begin failures++; $display("FAIL reset_pol_hsync got=%b exp=0", hs_p); end
    checks++; if (vs_p !== 1'b0) begin failures++; $display("FAIL reset_pol_vsync got=%b exp=0", vs_p); end
    checks++; if (de_d !== 1'b0) begin failures++; $display("FAIL reset_dflt_de got=%b exp=0", de_d); end
  endtask

  task automatic test_small_frame();
    int px, ly;
    logic e_de, e_hs, e_vs, e_sol, e_sof;
    do_reset();
    ce = 1'b1;
    for (int k = 1; k <= 49; k++) begin
      @(posedge clock);
      @(negedge clock);
      px    = (k - 1) % 8;
      ly    = ((k - 1) / 8) % 6;
      e_de  = DE_X[px] & DE_Y[ly];
      e_hs  = HS_X[px];
      e_vs  = VS_Y[ly];
      e_sol = (k == 1) || (k == 9) || (k == 17) || (k == 25) || (k == 33) || (k == 41) || (k == 49);
      e_sof = (k == 1) || (k == 49);
      checks++; if (x_s !== 12'(px)) begin failures++; $display("FAIL small_x clk=%0d got=%0d exp=%0d", k, x_s, px); end
      checks++; if (y_s !== 12'(ly)) begin failures++; $display("FAIL small_y clk=%0d got=%0d exp=%0d", k, y_s, ly); end
      checks++; if (de_s !== e_de) begin failures++; $display("FAIL small_de clk=%0d got=%b exp=%b", k, de_s, e_de); end
      checks++; if (hs_s !== e_hs) begin failures++; $display("FAIL small_hsync clk=%0d got=%b exp=%b", k, hs_s, e_hs); end
      checks++; if (vs_s !== e_vs) begin failures++; $display("FAIL small_vsync clk=%0d got=%b exp=%b", k, vs_s, e_vs); end
      checks++; if (sol_s !== e_sol) begin failures++; $display("FAIL small_sol clk=%0d got=%b exp=%b", k, sol_s, e_sol); end
      checks++; if (sof_s !== e_sof) begin failures++; $display("FAIL small_sof clk=%0d got=%b exp=%b", k, sof_s, e_sof); end
      checks++; if (hs_p !== ~e_hs) begin failures++; $display("FAIL pol_hsync clk=%0d got=%b exp=%b", k, hs_p, ~e_hs); end
      checks++; if (vs_p !== ~e_vs) begin failures++; $display("FAIL pol_vsync clk=%0d got=%b exp=%b", k, vs_p, ~e_vs); end
    end
  endtask

  task automatic test_ce_pattern();
    int n, ex, ey;
    logic e_de, e_sof, e_sol;
    do_reset();
    n = 0;
    for (int i = 0; i < 24; i++) begin
      ce = ((i % 4) == 0) || ((i % 4) == 3);
      @(posedge clock);
      @(negedge clock);
      if (ce) n++;
      ex    = (n - 1) % 8;
      ey    = (n - 1) / 8;
      e_de  = DE_X[ex] & DE_Y[ey];
      e_sof = ce && (n == 1);
      e_sol = ce && (ex == 0);
      checks++; if (x_s !== 12'(ex)) begin failures++; $display("FAIL ce_x i=%0d got=%0d exp=%0d", i, x_s, ex); end
      checks++; if (y_s !== 12'(ey)) begin failures++; $display("FAIL ce_y i=%0d got=%0d exp=%0d", i, y_s, ey); end
      checks++; if (de_s !== e_de) begin failures++; $display("FAIL ce_de i=%0d got=%b exp=%b", i, de_s, e_de); end
      checks++; if (sof_s !== e_sof) begin failures++; $display("FAIL ce_sof i=%0d got=%b exp=%b", i, sof_s, e_sof); end
      checks++; if (sol_s !== e_sol) begin failures++; $display("FAIL ce_sol i=%0d got=%b exp=%b", i, sol_s, e_sol); end
    end
  endtask

  task automatic test_default_lines();
    int run, total, hs_cnt, runs, sof_cnt;
    do_reset();
    ce = 1'b1;
    run = 0; total = 0; hs_cnt = 0; runs = 0; sof_cnt = 0;
    for (int k = 1; k <= 2400; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (de_d === 1'b1) begin
        run++;
        total++;
      end else if (run != 0) begin
        runs++;
        checks++; if (run != 640) begin failures++; $display("FAIL dflt_de_run clk=%0d got=%0d exp=640", k, run); end
        run = 0;
      end
      if (hs_d === 1'b0) hs_cnt++;
      if (sof_d === 1'b1) sof_cnt++;
      if (k == 801) begin
        checks++; if (x_d !== 12'd0 || y_d !== 12'd1 || sol_d !== 1'b1)
          begin failures++; $display("FAIL dflt_line1 got=x%0d y%0d sol%b exp=x0 y1 sol1", x_d, y_d, sol_d); end
      end
    end
    checks++; if (runs != 3) begin failures++; $display("FAIL dflt_runs got=%0d exp=3", runs); end
    checks++; if (total != 1920) begin failures++; $display("FAIL dflt_de_total got=%0d exp=1920", total); end
    checks++; if (hs_cnt != 288) begin failures++; $display("FAIL dflt_hsync_cnt got=%0d exp=288", hs_cnt); end
    checks++; if (sof_cnt != 1) begin failures++; $display("FAIL dflt_sof_cnt got=%0d exp=1", sof_cnt); end
    checks++; if (vs_d !== 1'b1) begin failures++; $display("FAIL dflt_vsync got=%b exp=1", vs_d); end
  endtask

  task automatic test_mid_reset();
    repeat (301) @(posedge clock);
    @(negedge clock);
    checks++; if (x_d !== 12'd300 || y_d !== 12'd3) begin failures++; $display("FAIL mid_pos got=x%0d y%0d exp=x300 y3", x_d, y_d); end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++; if (de_d !== 1'b0) begin failures++; $display("FAIL mid_rst_de got=%b exp=0", de_d); end
    checks++; if (hs_d !== 1'b1 || vs_d !== 1'b1) begin failures++; $display("FAIL mid_rst_sync got=%b%b exp=11", hs_d, vs_d); end
    checks++; if (x_d !== 12'd0 || y_d !== 12'd0) begin failures++; $display("FAIL mid_rst_pos got=x%0d y%0d exp=x0 y0", x_d, y_d); end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++; if (x_d !== 12'd0 || y_d !== 12'd0) begin failures++; $display("FAIL post_rst_pos got=x%0d y%0d exp=x0 y0", x_d, y_d); end
    checks++; if (de_d !== 1'b1) begin failures++; $display("FAIL post_rst_de got=%b exp=1", de_d); end
    checks++; if (sof_d !== 1'b1 || sol_d !== 1'b1) begin failures++; $display("FAIL post_rst_strobes got=sof%b sol%b exp=11", sof_d, sol_d); end
    @(posedge clock);
    @(negedge clock);
    checks++; if (x_d !== 12'd1 || sof_d !== 1'b0) begin failures++; $display("FAIL post_rst_next got=x%0d sof%b exp=x1 sof0", x_d, sof_d); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    ce       = 1'b0;
    test_reset();
    test_small_frame();
    test_ce_pattern();
    test_default_lines();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
